// File: rtl/tamagotchi_energy_core.sv
// Energy-need engine for the pet. It debounces the orientation sensor, keeps a saturating
// energy level driven by a base tick, tracks the pet's condition and scans a 4-digit display.
//
//   state     | meaning
//   AWAKE     | face up, level above TIRED_LVL
//   TIRED     | face up, level in 1..TIRED_LVL
//   EXHAUSTED | face up, level at 0
//   SLEEP     | face down (debounced), level recovering
module tamagotchi_energy_core #(
  parameter int TICK_DIV      = 50_000_000,
  parameter int DECAY_TICKS   = 10,
  parameter int RECOVER_TICKS = 5,
  parameter int LEVEL_MAX     = 5,
  parameter int TIRED_LVL     = 2,
  parameter int DEB_CYCLES    = 1_000_000,
  parameter int SCAN_DIV      = 50_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ledsign,
  output logic [3:0] display_out,
  output logic [6:0] seg_display,
  output logic       clk_out
);

  localparam int TW      = $clog2(TICK_DIV);
  localparam int DW      = $clog2(DEB_CYCLES + 1);
  localparam int SUB_MAX = (DECAY_TICKS > RECOVER_TICKS) ? DECAY_TICKS : RECOVER_TICKS;
  localparam int SW      = $clog2(SUB_MAX + 1);
  localparam int CW      = $clog2(SCAN_DIV + 1);

  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [DW-1:0] DEB_LAST  = DW'(DEB_CYCLES);
  localparam logic [SW-1:0] DEC_LAST  = SW'(DECAY_TICKS - 1);
  localparam logic [SW-1:0] REC_LAST  = SW'(RECOVER_TICKS - 1);
  localparam logic [CW-1:0] SCAN_LAST = CW'(SCAN_DIV - 1);
  localparam logic [3:0]    LVL_MAX   = 4'(LEVEL_MAX);
  localparam logic [3:0]    LVL_TIRED = 4'(TIRED_LVL);

  typedef enum logic [1:0] {ST_AWAKE, ST_TIRED, ST_EXHAUSTED, ST_SLEEP} state_t;

  function automatic logic [6:0] level_seg(input logic [3:0] lvl);
    case (lvl)
      4'd0:    level_seg = 7'h40;
      4'd1:    level_seg = 7'h79;
      4'd2:    level_seg = 7'h24;
      4'd3:    level_seg = 7'h30;
      4'd4:    level_seg = 7'h19;
      4'd5:    level_seg = 7'h12;
      4'd6:    level_seg = 7'h02;
      4'd7:    level_seg = 7'h78;
      4'd8:    level_seg = 7'h00;
      4'd9:    level_seg = 7'h10;
      default: level_seg = 7'h7F;
    endcase
  endfunction

  function automatic logic [6:0] state_seg(input state_t st);
    case (st)
      ST_AWAKE:     state_seg = 7'h08;
      ST_TIRED:     state_seg = 7'h07;
      ST_EXHAUSTED: state_seg = 7'h06;
      default:      state_seg = 7'h47;
    endcase
  endfunction

  logic          sync1_q, sync2_q;
  logic          sleep_req_q;
  logic [DW-1:0] deb_cnt_q;
  logic [TW-1:0] tick_cnt_q;
  logic          clk_out_q;
  logic [SW-1:0] sub_q, sub_d;
  logic [3:0]    level_q, level_d;
  state_t        state_q, state_d;
  logic [CW-1:0] scan_cnt_q;
  logic [1:0]    digit_q, digit_d;
  logic [3:0]    an_q, an_d;
  logic [6:0]    seg_q, seg_d;
  logic          tick, sleep_edge;
  logic [SW-1:0] period_last;

  always_comb begin
    tick        = (tick_cnt_q == TICK_LAST);
    sleep_edge  = (state_q == ST_SLEEP) != sleep_req_q;
    period_last = (state_q == ST_SLEEP) ? REC_LAST : DEC_LAST;
    sub_d       = sub_q;
    level_d     = level_q;
    // entering or leaving SLEEP restarts the tick count and suppresses that cycle's step
    if (sleep_edge) begin
      sub_d = '0;
    end else if (tick) begin
      if (sub_q == period_last) begin
        sub_d = '0;
        if (state_q == ST_SLEEP) begin
          if (level_q != LVL_MAX) level_d = level_q + 4'd1;
        end else if (level_q != 4'd0) begin
          level_d = level_q - 4'd1;
        end
      end else begin
        sub_d = sub_q + SW'(1);
      end
    end

    if (sleep_req_q)              state_d = ST_SLEEP;
    else if (level_q == 4'd0)     state_d = ST_EXHAUSTED;
    else if (level_q <= LVL_TIRED) state_d = ST_TIRED;
    else                          state_d = ST_AWAKE;

    digit_d = digit_q + 2'd1;
    case (digit_d)
      2'd0:    begin an_d = 4'b1110; seg_d = level_seg(level_q); end
      2'd1:    begin an_d = 4'b1101; seg_d = 7'h7F; end
      2'd2:    begin an_d = 4'b1011; seg_d = 7'h7F; end
      default: begin an_d = 4'b0111; seg_d = state_seg(state_q); end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q     <= 1'b1;
      sync2_q     <= 1'b1;
      sleep_req_q <= 1'b0;
      deb_cnt_q   <= '0;
      tick_cnt_q  <= '0;
      clk_out_q   <= 1'b0;
      sub_q       <= '0;
      level_q     <= LVL_MAX;
      state_q     <= ST_AWAKE;
      scan_cnt_q  <= '0;
      digit_q     <= 2'd0;
      an_q        <= 4'b1110;
      seg_q       <= level_seg(LVL_MAX);
    end else begin
      sync1_q <= ledsign;
      sync2_q <= sync1_q;
      // sync2 equal to sleep_req means the raw level disagrees with the accepted one
      if (sync2_q == sleep_req_q) begin
        if (deb_cnt_q == DEB_LAST) begin
          sleep_req_q <= ~sleep_req_q;
          deb_cnt_q   <= '0;
        end else begin
          deb_cnt_q <= deb_cnt_q + DW'(1);
        end
      end else begin
        deb_cnt_q <= '0;
      end

      if (tick) begin
        tick_cnt_q <= '0;
        clk_out_q  <= ~clk_out_q;
      end else begin
        tick_cnt_q <= tick_cnt_q + TW'(1);
      end

      sub_q   <= sub_d;
      level_q <= level_d;
      state_q <= state_d;

      if (scan_cnt_q == SCAN_LAST) begin
        scan_cnt_q <= '0;
        digit_q    <= digit_d;
        an_q       <= an_d;
        seg_q      <= seg_d;
      end else begin
        scan_cnt_q <= scan_cnt_q + CW'(1);
      end
    end
  end

  assign display_out = an_q;
  assign seg_display = seg_q;
  assign clk_out     = clk_out_q;

endmodule

// File: tb/tb_tamagotchi_energy_core.sv
// Randomised and directed bench for tamagotchi_energy_core against a cycle-indexed
// behavioural model of the sensor, tick, energy and display rules.
module tb_tamagotchi_energy_core;

  localparam int TICK_DIV      = 4;
  localparam int DECAY_TICKS   = 2;
  localparam int RECOVER_TICKS = 1;
  localparam int LEVEL_MAX     = 5;
  localparam int TIRED_LVL     = 2;
  localparam int DEB_CYCLES    = 3;
  localparam int SCAN_DIV      = 2;

  localparam int S_AWAKE = 0, S_TIRED = 1, S_EXH = 2, S_SLEEP = 3;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ledsign;
  logic [3:0] display_out;
  logic [6:0] seg_display;
  logic       clk_out;

  tamagotchi_energy_core #(
    .TICK_DIV(TICK_DIV), .DECAY_TICKS(DECAY_TICKS), .RECOVER_TICKS(RECOVER_TICKS),
    .LEVEL_MAX(LEVEL_MAX), .TIRED_LVL(TIRED_LVL), .DEB_CYCLES(DEB_CYCLES), .SCAN_DIV(SCAN_DIV)
  ) dut (
    .clk(clk), .rst_n(rst_n), .ledsign(ledsign),
    .display_out(display_out), .seg_display(seg_display), .clk_out(clk_out)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [6:0] num_code(input int v);
    case (v)
      0: num_code = 7'h40;  1: num_code = 7'h79;  2: num_code = 7'h24;
      3: num_code = 7'h30;  4: num_code = 7'h19;  5: num_code = 7'h12;
      6: num_code = 7'h02;  7: num_code = 7'h78;  8: num_code = 7'h00;
      9: num_code = 7'h10;  default: num_code = 7'h7F;
    endcase
  endfunction

  function automatic logic [6:0] letter_code(input int s);
    case (s)
      S_AWAKE: letter_code = 7'h08;
      S_TIRED: letter_code = 7'h07;
      S_EXH:   letter_code = 7'h06;
      default: letter_code = 7'h47;
    endcase
  endfunction

  // model state: cycle index since reset release and the spec-level quantities
  int         m_c, m_level, m_state, m_sub;
  bit         m_sleep;
  bit         h[DEB_CYCLES+3];
  logic [3:0] exp_an;
  logic [6:0] exp_seg;
  int         exp_clk;
  logic [6:0] seen_seg[4];

  task automatic model_reset();
    m_c = 0; m_level = LEVEL_MAX; m_state = S_AWAKE; m_sub = 0; m_sleep = 1'b0;
    for (int k = 0; k < DEB_CYCLES + 3; k++) h[k] = 1'b1;
    exp_an = 4'b1110; exp_seg = num_code(LEVEL_MAX); exp_clk = 0;
  endtask

  task automatic model_step(input bit ls);
    int old_level, old_state, dig;
    bit old_sleep, tick, all_diff, acc_ls;
    old_level = m_level; old_state = m_state; old_sleep = m_sleep;
    m_c++;
    for (int k = DEB_CYCLES + 2; k > 0; k--) h[k] = h[k-1];
    h[0] = ls;

    if (m_c % SCAN_DIV == 0) begin
      dig = (m_c / SCAN_DIV) % 4;
      case (dig)
        0: begin exp_an = 4'b1110; exp_seg = num_code(old_level); end
        1: begin exp_an = 4'b1101; exp_seg = 7'h7F; end
        2: begin exp_an = 4'b1011; exp_seg = 7'h7F; end
        default: begin exp_an = 4'b0111; exp_seg = letter_code(old_state); end
      endcase
    end
    exp_clk = (m_c / TICK_DIV) % 2;
    tick = (m_c % TICK_DIV == 0);

    if ((old_state == S_SLEEP) != old_sleep) begin
      m_sub = 0;
    end else if (tick) begin
      m_sub++;
      if (old_state == S_SLEEP) begin
        if (m_sub == RECOVER_TICKS) begin
          m_sub = 0;
          if (m_level < LEVEL_MAX) m_level++;
        end
      end else if (m_sub == DECAY_TICKS) begin
        m_sub = 0;
        if (m_level > 0) m_level--;
      end
    end

    if (old_sleep)                   m_state = S_SLEEP;
    else if (old_level == 0)         m_state = S_EXH;
    else if (old_level <= TIRED_LVL) m_state = S_TIRED;
    else                             m_state = S_AWAKE;

    // accepted level flips once DEB_CYCLES+1 synchronised samples in a row disagree
    acc_ls = !old_sleep;
    all_diff = 1'b1;
    for (int k = 2; k <= DEB_CYCLES + 2; k++) if (h[k] == acc_ls) all_diff = 1'b0;
    if (all_diff) m_sleep = !old_sleep;
  endtask

  task automatic cycle(input bit ls);
    ledsign = ls;
    @(posedge clk);
    model_step(ls);
    @(negedge clk);
    check_val("display_out", display_out, exp_an);
    check_val("seg_display", seg_display, exp_seg);
    check_val("clk_out", clk_out, exp_clk);
    case (display_out)
      4'b1110: seen_seg[0] = seg_display;
      4'b1101: seen_seg[1] = seg_display;
      4'b1011: seen_seg[2] = seg_display;
      4'b0111: seen_seg[3] = seg_display;
      default: ;
    endcase
  endtask

  task automatic check_reset_outputs(input string tag);
    check_val({tag, "_an"},  display_out, 4'b1110);
    check_val({tag, "_seg"}, seg_display, 7'h12);
    check_val({tag, "_clk"}, clk_out, 1'b0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    int budget, total;
    bit found, v;
    for (int i = 0; i < 4; i++) seen_seg[i] = 7'h00;
    rst_n = 1'b0; ledsign = 1'b1;
    model_reset();
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;

    // decay to exhaustion while face up
    repeat (70) cycle(1'b1);
    check_val("exh_letter", seen_seg[3], 7'h06);
    check_val("level_zero", seen_seg[0], 7'h40);
    check_val("blank_d1", seen_seg[1], 7'h7F);
    check_val("blank_d2", seen_seg[2], 7'h7F);

    // sleep and recover to saturation
    repeat (45) cycle(1'b0);
    check_val("sleep_letter", seen_seg[3], 7'h47);
    check_val("level_full", seen_seg[0], 7'h12);

    // wake, then a short glitch that must be ignored
    repeat (8) cycle(1'b1);
    cycle(1'b0); cycle(1'b0);
    repeat (8) cycle(1'b1);
    check_val("awake_letter", seen_seg[3], 7'h08);

    // random sensor activity
    total = 0;
    while (total < 500) begin
      v = 1'($urandom_range(0, 1));
      budget = $urandom_range(1, 14);
      repeat (budget) cycle(v);
      total += budget;
    end

    // reach SLEEP at level 3, then reset asynchronously
    budget = 0;
    while (m_level != 0 && budget < 100) begin cycle(1'b1); budget++; end
    budget = 0; found = 1'b0;
    while (!found && budget < 100) begin
      cycle(1'b0); budget++;
      found = (m_state == S_SLEEP) && (m_level == 3);
    end
    check_val("reach_sleep_l3", found, 1'b1);
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("async_rst");
    @(negedge clk);
    check_reset_outputs("rst_hold");
    rst_n = 1'b1;
    model_reset();
    repeat (30) cycle(1'b0);
    check_val("resleep_letter", seen_seg[3], 7'h47);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
